// File: rtl/branch_predictor_ahr.sv
// Local-history (AHR) branch predictor: direct-mapped BTB plus shared 2-bit PHT.
// Define BRPRED_STATS_EN to add update/mispredict counters.
module branch_predictor_ahr #(
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        en,
  input  logic        br,
  input  logic [31:0] tgt,
  output logic        hit,
  output logic        taken,
  output logic [31:0] prdbr
`ifdef BRPRED_STATS_EN
  ,
  output logic [31:0] num_upd,
  output logic [31:0] num_mispred
`endif
);

  localparam int N     = 1 << IDX_W;
  localparam int P     = 1 << HIST_W;
  localparam int TAG_W = 32 - IDX_W;

  logic              valid_q [N];
  logic [TAG_W-1:0]  tag_q   [N];
  logic [31:0]       tgt_q   [N];
  logic [HIST_W-1:0] hist_q  [N];
  logic [1:0]        pht_q   [P];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [HIST_W-1:0] hist_cur;
  logic [1:0]        ctr_cur;

  logic [1:0]        ctr_d;
  logic [HIST_W-1:0] hist_d;
  logic [31:0]       tgt_d;

  assign idx      = pc[IDX_W-1:0];
  assign tag      = pc[31:IDX_W];
  assign hist_cur = hist_q[idx];
  assign ctr_cur  = pht_q[hist_cur];

  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign taken = hit && ctr_cur[1];
  assign prdbr = taken ? tgt_q[idx] : pc + 32'd1;

  always_comb begin
    ctr_d = ctr_cur;
    if (br && ctr_cur != 2'b11)
      ctr_d = ctr_cur + 2'd1;
    else if (!br && ctr_cur != 2'b00)
      ctr_d = ctr_cur - 2'd1;
  end

  // A miss restarts the history; a not-taken hit keeps the old target.
  always_comb begin
    hist_d = {{(HIST_W-1){1'b0}}, br};
    tgt_d  = tgt;
    if (hit) begin
      hist_d = {hist_cur[HIST_W-2:0], br};
      if (!br)
        tgt_d = tgt_q[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        hist_q[i]  <= '0;
      end
      for (int j = 0; j < P; j++)
        pht_q[j] <= 2'b01;
    end else if (en) begin
      valid_q[idx] <= 1'b1;
      tag_q[idx]   <= tag;
      tgt_q[idx]   <= tgt_d;
      hist_q[idx]  <= hist_d;
      if (hit)
        pht_q[hist_cur] <= ctr_d;
    end
  end

`ifdef BRPRED_STATS_EN
  logic [31:0] upd_q, upd_d;
  logic [31:0] mis_q, mis_d;
  logic        mispred;

  assign mispred = (taken != br) ||
                   (taken && br && (tgt_q[idx] != tgt));

  always_comb begin
    upd_d = upd_q;
    mis_d = mis_q;
    if (en) begin
      upd_d = upd_q + 32'd1;
      if (mispred)
        mis_d = mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q <= '0;
      mis_q <= '0;
    end else begin
      upd_q <= upd_d;
      mis_q <= mis_d;
    end
  end

  assign num_upd     = upd_q;
  assign num_mispred = mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor_ahr.sv
// Directed scoreboard bench for branch_predictor_ahr.
module tb_branch_predictor_ahr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        en;
  logic        br;
  logic [31:0] tgt;
  logic        hit;
  logic        taken;
  logic [31:0] prdbr;
`ifdef BRPRED_STATS_EN
  logic [31:0] num_upd;
  logic [31:0] num_mispred;
  logic [31:0] mis_before;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic        h;
    logic        t;
    logic [31:0] p;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_predictor_ahr dut (
    .clk   (clk),
    .rst   (rst),
    .pc    (pc),
    .en    (en),
    .br    (br),
    .tgt   (tgt),
    .hit   (hit),
    .taken (taken),
`ifdef BRPRED_STATS_EN
    .num_upd     (num_upd),
    .num_mispred (num_mispred),
`endif
    .prdbr (prdbr)
  );

  task automatic push(input string n, input logic h,
                      input logic t, input logic [31:0] p);
    exp_t e;
    e.name = n;
    e.h = h;
    e.t = t;
    e.p = p;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    #1;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard: empty queue");
    end else begin
      e = sb.pop_front();
      assert (hit === e.h && taken === e.t && prdbr === e.p)
      else begin
        miscompares++;
        $error("FAIL %s: got hit=%b taken=%b prdbr=%0d, want hit=%b taken=%b prdbr=%0d",
               e.name, hit, taken, prdbr, e.h, e.t, e.p);
      end
    end
  endtask

  task automatic lookup(input string n, input logic [31:0] a,
                        input logic h, input logic t,
                        input logic [31:0] p);
    pc = a;
    en = 1'b0;
    push(n, h, t, p);
    check();
  endtask

  task automatic update(input logic [31:0] a, input logic b,
                        input logic [31:0] t);
    pc  = a;
    br  = b;
    tgt = t;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pc  = 32'd1024;
    en  = 1'b0;
    br  = 1'b0;
    tgt = 32'd0;
    push("in_reset", 1'b0, 1'b0, 32'd1025);
    check();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    lookup("after_reset", 32'd1024, 1'b0, 1'b0, 32'd1025);

    update(32'd1024, 1'b1, 32'd2048);
    lookup("alloc_1024", 32'd1024, 1'b1, 1'b0, 32'd1025);

    for (int k = 0; k < 3; k++)
      update(32'd1024, 1'b1, 32'd2048);
    lookup("train_4", 32'd1024, 1'b1, 1'b0, 32'd1025);
    update(32'd1024, 1'b1, 32'd2048);
    lookup("train_5", 32'd1024, 1'b1, 1'b1, 32'd2048);

`ifdef BRPRED_STATS_EN
    mis_before = num_mispred;
`endif
    update(32'd1024, 1'b0, 32'd2048);
    lookup("not_taken", 32'd1024, 1'b1, 1'b0, 32'd1025);
`ifdef BRPRED_STATS_EN
    vectors++;
    assert (num_mispred === mis_before + 32'd1)
    else begin
      miscompares++;
      $error("FAIL mispred_cnt: got %0d, want %0d",
             num_mispred, mis_before + 32'd1);
    end
`endif

    lookup("other_idx", 32'd1025, 1'b0, 1'b0, 32'd1026);
    lookup("alias_miss", 32'd1040, 1'b0, 1'b0, 32'd1041);

    update(32'd1040, 1'b1, 32'd500);
    lookup("replace_hit", 32'd1040, 1'b1, 1'b1, 32'd500);
    lookup("evicted", 32'd1024, 1'b0, 1'b0, 32'd1025);

    pc = 32'd1040;
    #2;
    rst = 1'b1;
    push("async_rst", 1'b0, 1'b0, 32'd1041);
    check();
    @(negedge clk);
    rst = 1'b0;

    pc  = 32'd1040;
    br  = 1'b1;
    tgt = 32'd77;
    repeat (3) @(posedge clk);
    #1;
    lookup("idle_no_upd", 32'd1040, 1'b0, 1'b0, 32'd1041);

    update(32'd1040, 1'b1, 32'd500);
    lookup("pht_reset", 32'd1040, 1'b1, 1'b0, 32'd1041);

    lookup("pc_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
